encoder_rr: RTL and testbench
=============================

ENCODER_RR -- requirements
Module: encoder_rr

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8, number of request lines (legal range 1..256).
REQ-002 SHALL derive OUT_WIDTH = max(1, $clog2(IN_WIDTH)) internally; OUT_WIDTH is not overridable.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in  input  IN_WIDTH  multi-hot request vector.
REQ-006 SHALL have port in_valid  input  1  in holds a vector.
REQ-007 SHALL have port in_ready  output  1  block can accept a vector.
REQ-008 SHALL have port out  output  OUT_WIDTH  binary index of the granted bit.
REQ-009 SHALL have port out_valid  output  1  out holds an index.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out.
REQ-011 SHALL have port out_last  output  1  current index is the last pending bit of the vector.

Function
REQ-012 SHALL accept a vector on a rising edge where in_valid and in_ready are both 1, copying in into a pending mask.
REQ-013 SHALL implement two states: IDLE (pending empty) and BUSY (pending non-empty).
REQ-014 SHALL drive in_ready = 1 in IDLE, or in BUSY during the out handshake that consumes the last pending bit; otherwise 0.
REQ-015 SHALL move IDLE->BUSY on acceptance of a non-zero vector, and BUSY->IDLE on the handshake of the last pending bit unless a new non-zero vector is accepted on that edge (stay BUSY).
REQ-016 SHALL accept an all-zero vector, produce no output, and remain IDLE.
REQ-017 SHALL drive out_valid = 1 exactly while BUSY; first out_valid appears one cycle after acceptance.
REQ-018 SHALL select, in BUSY, the lowest-index pending bit at or above the round-robin pointer, wrapping to index 0 if none are at or above it.
REQ-019 SHALL drive out_last = 1 when the selected bit is the only pending bit.
REQ-020 SHALL, on each out handshake (out_valid and out_ready), clear the granted bit and set pointer = granted index + 1, wrapping to 0 at IN_WIDTH (also for non-power-of-2 IN_WIDTH).
REQ-021 SHALL keep the pointer across vectors; it changes only on out handshakes and reset.
REQ-022 SHALL hold out, out_last and the pending mask stable while out_valid = 1 and out_ready = 0.
REQ-023 SHALL drive out = 0 and out_last = 0 whenever out_valid = 0.
REQ-024 SHALL derive out, out_valid and out_last from registers only; there is no combinational path from in or in_valid to any output.
REQ-025 SHALL allow in_ready to depend combinationally on out_ready (REQ-014); back-to-back vectors then give continuous out_valid.
REQ-026 SHALL sustain one out handshake per cycle while out_ready = 1.

Reset
REQ-027 SHALL, while rst_n = 0, immediately force state IDLE, pending = 0, pointer = 0, out_valid = 0, out = 0, out_last = 0, in_ready = 1, with no vector accepted.
REQ-028 SHALL discard any pending bits when reset asserts mid-operation; first acceptance is possible on the first rising edge with rst_n = 1.

Verification (IN_WIDTH = 8 unless stated; out_ready = 1 unless stated)
REQ-029 SHALL cover: after reset, in = 8'b0010_0101 accepted -> out = 0, 2, 5 on three consecutive cycles, out_last only with 5, then in_ready = 1, pointer = 6.
REQ-030 SHALL cover: next in = 8'b0100_0011 -> out = 6, 0, 1 (round-robin wrap), out_last with 1.
REQ-031 SHALL cover: out_ready = 0 for 3 cycles while out = 2 pending -> out = 2, out_valid = 1, in_ready = 0 held all 3 cycles; release -> next index follows.
REQ-032 SHALL cover: in = 8'h00 accepted -> out_valid stays 0, in_ready stays 1; and a new vector 8'h80 presented on the edge consuming the last bit of 8'h03 -> accepted, out_valid continuous, out = 7 next.
REQ-033 SHALL cover: rst_n driven low mid-vector with 2 bits pending -> out_valid = 0 the same cycle, no further indices; the next vector 8'h01 yields out = 0.
REQ-034 SHALL cover: IN_WIDTH = 3, in = 3'b111 -> out = 0, 1, 2 with OUT_WIDTH = 2, pointer wraps to 0; and IN_WIDTH = 1, in = 1'b1 -> out = 0, out_last = 1.

Source files
------------

// File: rtl/encoder_rr.sv
// Round-robin multi-hot to binary encoder: accepts a request vector, then emits
// one granted index per handshake, starting at the rotating pointer.
module encoder_rr #(
  parameter  int IN_WIDTH  = 8,
  localparam int OUT_WIDTH = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IN_WIDTH-1:0]   r_pending;
  logic [IN_WIDTH-1:0]   w_pending_nxt;
  logic [IN_WIDTH-1:0]   w_pending_clr;
  logic [OUT_WIDTH-1:0]  r_ptr;
  logic [OUT_WIDTH-1:0]  w_ptr_nxt;
  logic [OUT_WIDTH-1:0]  w_hi_idx;
  logic [OUT_WIDTH-1:0]  w_lo_idx;
  logic                  w_hi_found;
  logic [OUT_WIDTH-1:0]  w_grant;
  logic                  w_last;
  logic                  w_busy;
  logic                  w_out_hs;
  logic                  w_accept;

  // Outputs depend only on r_state, r_pending and r_ptr, never on in/in_valid.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    // Descending scan: the last hit written is the lowest matching index.
    for (int i = IN_WIDTH - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_lo_idx = OUT_WIDTH'(i);
        if (i >= int'(r_ptr)) begin
          w_hi_idx   = OUT_WIDTH'(i);
          w_hi_found = 1'b1;
        end
      end
    end
    w_grant = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    w_pending_clr = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      w_pending_clr[i] = r_pending[i] && (OUT_WIDTH'(i) != w_grant);
    end
  end

  // A single set bit means the granted bit is the only one left.
  assign w_last   = ((r_pending & (r_pending - 1'b1)) == '0);
  assign w_busy   = (r_state == BUSY);
  assign w_out_hs = w_busy & out_ready;
  assign in_ready = ~w_busy | (w_out_hs & w_last);
  assign w_accept = in_valid & in_ready;

  assign out_valid = w_busy;
  assign out       = w_busy ? w_grant : '0;
  assign out_last  = w_busy & w_last;

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_ptr_nxt     = r_ptr;
    if (w_out_hs) begin
      w_pending_nxt = w_pending_clr;
      w_ptr_nxt     = (w_grant == OUT_WIDTH'(IN_WIDTH - 1)) ? '0 : w_grant + OUT_WIDTH'(1);
      if (w_last) begin
        w_state_nxt = IDLE;
      end
    end
    // Acceptance only happens with pending empty or emptying, so it simply overwrites.
    if (w_accept) begin
      w_pending_nxt = in;
      w_state_nxt   = (|in) ? BUSY : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_ptr     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_encoder_rr.sv
// Self-checking bench for encoder_rr: directed scenarios at widths 8, 3 and 1,
// plus randomized traffic at width 8 compared against a rotating-scan model.
module tb_encoder_rr;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [7:0] in8;
  logic       iv8, ir8, ov8, ord8, ol8;
  logic [2:0] out8;

  logic [2:0] in3;
  logic       iv3, ir3, ov3, ord3, ol3;
  logic [1:0] out3;

  logic [0:0] in1;
  logic       iv1, ir1, ov1, ord1, ol1;
  logic [0:0] out1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  encoder_rr #(.IN_WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .in_valid(iv8), .in_ready(ir8),
    .out(out8), .out_valid(ov8), .out_ready(ord8), .out_last(ol8)
  );

  encoder_rr #(.IN_WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in(in3), .in_valid(iv3), .in_ready(ir3),
    .out(out3), .out_valid(ov3), .out_ready(ord3), .out_last(ol3)
  );

  encoder_rr #(.IN_WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .in_valid(iv1), .in_ready(ir1),
    .out(out1), .out_valid(ov1), .out_ready(ord1), .out_last(ol1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect8(input string name, input int v, input int o, input int l, input int r);
    #1;
    check({name, ".valid"}, 32'(ov8), v);
    check({name, ".out"},   32'(out8), o);
    check({name, ".last"},  32'(ol8), l);
    check({name, ".ready"}, 32'(ir8), r);
  endtask

  task automatic expect3(input string name, input int v, input int o, input int l, input int r);
    #1;
    check({name, ".valid"}, 32'(ov3), v);
    check({name, ".out"},   32'(out3), o);
    check({name, ".last"},  32'(ol3), l);
    check({name, ".ready"}, 32'(ir3), r);
  endtask

  task automatic expect1(input string name, input int v, input int o, input int l, input int r);
    #1;
    check({name, ".valid"}, 32'(ov1), v);
    check({name, ".out"},   32'(out1), o);
    check({name, ".last"},  32'(ol1), l);
    check({name, ".ready"}, 32'(ir1), r);
  endtask

  // Reference for the width-8 instance: the pending set and the pointer, with
  // the grant found by walking indices ptr, ptr+1, ... modulo 8.
  bit [7:0] m_pend = '0;
  int       m_ptr  = 0;

  always @(negedge clk) begin
    bit e_v, e_last, e_rdy;
    int e_idx;
    if (!rst_n) begin
      m_pend = '0;
      m_ptr  = 0;
      check("mdl.rst.valid", 32'(ov8), 0);
      check("mdl.rst.out",   32'(out8), 0);
      check("mdl.rst.last",  32'(ol8), 0);
      check("mdl.rst.ready", 32'(ir8), 1);
    end else begin
      e_v   = (m_pend != 0);
      e_idx = 0;
      if (e_v) begin
        for (int k = 7; k >= 0; k--) begin
          if (m_pend[(m_ptr + k) % 8]) e_idx = (m_ptr + k) % 8;
        end
      end
      e_last = e_v && ($countones(m_pend) == 1);
      e_rdy  = !e_v || (ord8 && e_last);
      check("mdl.valid", 32'(ov8), 32'(e_v));
      check("mdl.out",   32'(out8), e_idx);
      check("mdl.last",  32'(ol8), 32'(e_last));
      check("mdl.ready", 32'(ir8), 32'(e_rdy));
      if (e_v && ord8) begin
        m_pend[e_idx] = 1'b0;
        m_ptr = (e_idx + 1) % 8;
      end
      if (iv8 && e_rdy) m_pend = in8;
    end
  end

  initial begin
    rst_n = 1'b0;
    in8 = '0; iv8 = 1'b0; ord8 = 1'b1;
    in3 = '0; iv3 = 1'b0; ord3 = 1'b1;
    in1 = '0; iv1 = 1'b0; ord1 = 1'b1;
    #2;
    expect8("reset", 0, 0, 0, 1);
    repeat (3) tick();
    rst_n = 1'b1;
    expect8("idle", 0, 0, 0, 1);

    // Three grants in index order, last flagged on 5; pointer ends at 6.
    in8 = 8'b0010_0101; iv8 = 1'b1; tick(); iv8 = 1'b0;
    expect8("v25_a", 1, 0, 0, 0); tick();
    expect8("v25_b", 1, 2, 0, 0); tick();
    expect8("v25_c", 1, 5, 1, 1); tick();
    expect8("v25_end", 0, 0, 0, 1);

    // Starts at 6 and wraps to 0 then 1.
    in8 = 8'b0100_0011; iv8 = 1'b1; tick(); iv8 = 1'b0;
    expect8("v43_a", 1, 6, 0, 0); tick();
    expect8("v43_b", 1, 0, 0, 0); tick();
    expect8("v43_c", 1, 1, 1, 1); tick();
    expect8("v43_end", 0, 0, 0, 1);

    // Backpressure on index 2 for three cycles.
    in8 = 8'h0C; iv8 = 1'b1; tick(); iv8 = 1'b0; ord8 = 1'b0;
    expect8("stall_1", 1, 2, 0, 0); tick();
    expect8("stall_2", 1, 2, 0, 0); tick();
    expect8("stall_3", 1, 2, 0, 0); tick();
    ord8 = 1'b1;
    expect8("stall_rel", 1, 2, 0, 0); tick();
    expect8("stall_next", 1, 3, 1, 1); tick();
    expect8("stall_end", 0, 0, 0, 1);

    // All-zero vector produces nothing.
    in8 = 8'h00; iv8 = 1'b1; tick(); iv8 = 1'b0;
    expect8("zero", 0, 0, 0, 1);

    // Pointer at 4: 8'h03 wraps to 0, then 8'h80 rides the last-bit handshake.
    in8 = 8'h03; iv8 = 1'b1; tick(); iv8 = 1'b0;
    expect8("b2b_a", 1, 0, 0, 0); tick();
    expect8("b2b_b", 1, 1, 1, 1);
    in8 = 8'h80; iv8 = 1'b1; tick(); iv8 = 1'b0;
    expect8("b2b_c", 1, 7, 1, 1); tick();
    expect8("b2b_end", 0, 0, 0, 1);

    // Reset mid-vector with bits 1 and 2 still pending.
    in8 = 8'h07; iv8 = 1'b1; tick(); iv8 = 1'b0;
    expect8("mid_a", 1, 0, 0, 0); tick();
    expect8("mid_b", 1, 1, 0, 0);
    rst_n = 1'b0;
    expect8("mid_rst", 0, 0, 0, 1); tick();
    expect8("mid_rst2", 0, 0, 0, 1);
    rst_n = 1'b1;
    in8 = 8'h01; iv8 = 1'b1; tick(); iv8 = 1'b0;
    expect8("post_rst", 1, 0, 1, 1); tick();
    expect8("post_end", 0, 0, 0, 1);

    // Non-power-of-two width: pointer must wrap from 2 back to 0.
    in3 = 3'b111; iv3 = 1'b1; tick(); iv3 = 1'b0;
    expect3("w3_a", 1, 0, 0, 0); tick();
    expect3("w3_b", 1, 1, 0, 0); tick();
    expect3("w3_c", 1, 2, 1, 1); tick();
    expect3("w3_end", 0, 0, 0, 1);
    in3 = 3'b101; iv3 = 1'b1; tick(); iv3 = 1'b0;
    expect3("w3_wrap_a", 1, 0, 0, 0); tick();
    expect3("w3_wrap_b", 1, 2, 1, 1); tick();

    // Single request line.
    in1 = 1'b1; iv1 = 1'b1; tick(); iv1 = 1'b0;
    expect1("w1_a", 1, 0, 1, 1); tick();
    expect1("w1_end", 0, 0, 0, 1);

    // Random traffic, checked every cycle by the model process.
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0:       in8 = 8'h00;
        1:       in8 = 8'(1) << $urandom_range(0, 7);
        2:       in8 = 8'($urandom) & 8'($urandom);
        default: in8 = 8'($urandom);
      endcase
      iv8   = 1'($urandom_range(0, 1));
      ord8  = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    iv8   = 1'b0;
    ord8  = 1'b1;
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
